instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the single-cycle RISC-V core. Owns the program counter and drives it to the combinational instruction memory. Registers the returned word together with its PC into a one-entry fetch slot that the decoder drains through a valid/ready handshake. Handles control-flow redirects from execute and halts on an illegal fetch address.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words; legal fetch range is 0 .. 4*IMEM_DEPTH-4.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc  out  32  current fetch address to instruction memory.
- instruction  in  32  word returned combinationally for `pc`.
- redirect_valid  in  1  execute requests a jump/branch this cycle.
- redirect_target  in  32  new PC when redirect_valid=1.
- if_valid  out  1  fetch slot holds a valid instruction.
- if_ready  in  1  decoder accepts the slot this cycle.
- if_pc  out  32  PC of the instruction in the slot.
- if_instruction  out  32  instruction in the slot.
- fault  out  1  sticky; fetch halted.
- fault_cause  out  2  2'b01 misaligned redirect, 2'b10 address out of range, 2'b00 none.
- fetch_count  out  32  number of completed handshakes (if_valid & if_ready).

## Operation
- State machine with states BOOT, RUN and HALT; reset enters BOOT.
- BOOT: a one-cycle bubble with no capture; moves to RUN on the next edge.
- RUN, priority order, evaluated each cycle:
  1. redirect_valid=1:
     - if_valid <= 0, which flushes the slot even if a handshake is occurring. That handshake is ignored and fetch_count does not increment.
     - If redirect_target[1:0] != 0: go to HALT with fault_cause=01; pc is unchanged.
     - Otherwise pc <= redirect_target.
  2. Otherwise, the slot is free when if_valid=0 or (if_valid & if_ready):
     - If pc >= 4*IMEM_DEPTH: go to HALT with fault_cause=10 and if_valid <= 0.
     - Otherwise capture if_pc <= pc and if_instruction <= instruction, set if_valid <= 1, and advance pc <= pc+4 (32-bit arithmetic, wraps modulo 2^32).
  3. Otherwise (stalled): hold pc and all slot contents.
- HALT:
  - fault=1; if_valid is forced to 0.
  - pc, fault_cause and fetch_count are frozen.
  - redirect_valid and if_ready are ignored.
  - Exit only through reset.
- fetch_count increments on every cycle with if_valid & if_ready & !redirect_valid, and wraps at 2^32.
- if_pc and if_instruction must not change while if_valid=1 and if_ready=0.

## Timing
- Reset values:
  - pc = RESET_PC.
  - if_valid = 0, if_pc = 0, if_instruction = 0.
  - fault = 0, fault_cause = 0, fetch_count = 0.
- All outputs are registered. pc is a register output feeding memory combinationally, and `instruction` is sampled on the same edge that updates pc.
- After rst_n deasserts:
  - Edge 1: BOOT→RUN.
  - Edge 2: first capture (if_pc=RESET_PC, if_valid=1).
- Latency: one cycle from pc to the slot. Throughput: one instruction per cycle while if_ready=1.
- Redirect on edge N: the slot is empty after edge N, and the target instruction is valid after edge N+1. There is exactly one bubble.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of the current state or a pending handshake.
- Fault is raised on the edge that detects the condition and is visible in the following cycle.

## Test plan
- Straight-line fetch:
  - Stimulus: imem word0=0x00100093, word1=0x00108113, if_ready=1.
  - Required: after edge 2, if_pc=0 and if_instruction=0x00100093; after edge 3, if_pc=4 and if_instruction=0x00108113; fetch_count=2 after edge 4.
- Stall:
  - Stimulus: drop if_ready for 3 cycles while if_valid=1 and if_pc=4.
  - Required: if_pc, if_instruction and pc(=8) hold; fetch_count is unchanged; fetch resumes at 8 when if_ready returns.
- Redirect during stall:
  - Stimulus: if_ready=0 with slot at pc 8, then redirect_valid=1 with target 0x40.
  - Required: if_valid=0 the next cycle, then if_pc=0x40 the cycle after; the stalled word is never counted.
- Misaligned redirect:
  - Stimulus: target 0x42.
  - Required: fault=1, fault_cause=01, if_valid=0; all later redirects and if_ready toggles are ignored.
- Out of range:
  - Stimulus: IMEM_DEPTH=64, redirect to 0xFC, then run.
  - Required: 0xFC is delivered; the next capture attempt at 0x100 gives fault_cause=10 with if_valid=0.
- Reset mid-stall:
  - Stimulus: assert rst_n=0 asynchronously between edges.
  - Required: outputs go immediately to their reset values; after release, the BOOT bubble occurs, then if_pc=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, samples the combinational instruction memory and
// holds the result in a one-entry slot drained by the decoder via valid/ready.
// Redirects from execute flush the slot; an illegal fetch address halts fetch
// until reset.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;

    // First byte address past the end of instruction memory.
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_ins_q, if_ins_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] cnt_q, cnt_d;

    logic slot_free;
    logic handshake;

    assign slot_free = !vld_q || if_ready;
    // A handshake coinciding with a redirect is discarded along with the slot.
    assign handshake = (state_q == S_RUN) && vld_q && if_ready && !redirect_valid;

    // Next-state logic for the fetch FSM, PC and fetch slot.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        vld_d    = vld_q;
        if_pc_d  = if_pc_q;
        if_ins_d = if_ins_q;
        fault_d  = fault_q;
        cause_d  = cause_q;
        cnt_d    = handshake ? cnt_q + 32'd1 : cnt_q;

        case (state_q)
            S_BOOT: begin
                // Single bubble so memory sees RESET_PC for a full cycle.
                state_d = S_RUN;
            end
            S_RUN: begin
                if (redirect_valid) begin
                    vld_d = 1'b0;
                    if (redirect_target[1:0] != 2'b00) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_ALIGN;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (slot_free) begin
                    if (pc_q >= PC_LIMIT) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                        cause_d = CAUSE_RANGE;
                        vld_d   = 1'b0;
                    end else begin
                        if_pc_d  = pc_q;
                        if_ins_d = instruction;
                        vld_d    = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end
                end
            end
            S_HALT: begin
                // Everything frozen; only reset leaves this state.
                vld_d = 1'b0;
            end
            default: begin
                state_d = S_HALT;
                vld_d   = 1'b0;
                fault_d = 1'b1;
            end
        endcase
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            vld_q    <= 1'b0;
            if_pc_q  <= 32'd0;
            if_ins_q <= 32'd0;
            fault_q  <= 1'b0;
            cause_q  <= CAUSE_NONE;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            vld_q    <= vld_d;
            if_pc_q  <= if_pc_d;
            if_ins_q <= if_ins_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pc             = pc_q;
    assign if_valid       = vld_q;
    assign if_pc          = if_pc_q;
    assign if_instruction = if_ins_q;
    assign fault          = fault_q;
    assign fault_cause    = cause_q;
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural instruction memory, a scoreboard
// of expected (pc, word) pairs consumed on every decoder handshake, and
// directed checks for reset, stall, redirect and both fault causes.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    instruction_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instruction(if_instruction), .fault(fault),
        .fault_cause(fault_cause), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    assign instruction = (pc < 32'd256) ? mem[pc[7:2]] : 32'hDEAD_BEEF;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc  = a;
        e.ins = word_at(a);
        sb.push_back(e);
    endtask

    // Sampled mid-cycle: a handshake that will be honoured at the next edge.
    task automatic sb_sample();
        exp_t e;
        if (!rst_n) begin
            hs_cnt = 0;
        end else if (if_valid && if_ready && !redirect_valid) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_ins", if_instruction, e.ins);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_vld"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_ifpc"}, if_pc, 32'h0);
        chk({tag, "_ins"}, if_instruction, 32'h0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_cause"}, {30'd0, fault_cause}, 32'd0);
        chk({tag, "_cnt"}, fetch_count, 32'd0);
    endtask

    initial begin
        int saved_cnt;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i * 32'h0000_1013;
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0010_8113;

        rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        tick(); tick();
        chk_reset_vals("rst");

        // Straight-line fetch from RESET_PC.
        push_exp(32'h0); push_exp(32'h4);
        rst_n = 1'b1; if_ready = 1'b1;
        tick();
        chk("boot_vld", {31'd0, if_valid}, 32'd0);
        chk("boot_pc", pc, 32'h0);
        tick();
        chk("e2_vld", {31'd0, if_valid}, 32'd1);
        chk("e2_ifpc", if_pc, 32'h0);
        chk("e2_ins", if_instruction, 32'h0010_0093);
        chk("e2_pc", pc, 32'h4);
        tick();
        chk("e3_ifpc", if_pc, 32'h4);
        chk("e3_ins", if_instruction, 32'h0010_8113);
        chk("e3_cnt", fetch_count, 32'd1);
        tick();
        chk("e4_cnt", fetch_count, 32'd2);
        chk("e4_ifpc", if_pc, 32'h8);
        chk("e4_pc", pc, 32'hC);

        // Stall: slot and pc hold.
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_vld", {31'd0, if_valid}, 32'd1);
            chk("stall_ifpc", if_pc, 32'h8);
            chk("stall_ins", if_instruction, word_at(32'h8));
            chk("stall_pc", pc, 32'hC);
            chk("stall_cnt", fetch_count, 32'd2);
        end

        // Redirect with a simultaneous handshake: slot flushed, not counted.
        redirect_valid = 1'b1; redirect_target = 32'h40; if_ready = 1'b1;
        for (int i = 0; i < 24; i++) push_exp(32'h40 + 32'(4 * i));
        tick();
        chk("redir_vld", {31'd0, if_valid}, 32'd0);
        chk("redir_pc", pc, 32'h40);
        chk("redir_cnt", fetch_count, 32'd2);
        redirect_valid = 1'b0;
        tick();
        chk("redir_tgt_vld", {31'd0, if_valid}, 32'd1);
        chk("redir_tgt_ifpc", if_pc, 32'h40);
        chk("redir_tgt_pc", pc, 32'h44);

        // Random decoder back-pressure; scoreboard checks order and contents.
        for (int i = 0; i < 20; i++) begin
            if_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rand_cnt", fetch_count, 32'(hs_cnt));

        // Out of range: 0xFC delivered, capture at 0x100 faults.
        redirect_valid = 1'b1; redirect_target = 32'hFC; if_ready = 1'b1;
        sb.delete();
        push_exp(32'hFC);
        tick();
        chk("oor_redir_vld", {31'd0, if_valid}, 32'd0);
        chk("oor_redir_pc", pc, 32'hFC);
        redirect_valid = 1'b0;
        tick();
        chk("oor_fc_ifpc", if_pc, 32'hFC);
        chk("oor_fc_ins", if_instruction, word_at(32'hFC));
        chk("oor_fc_pc", pc, 32'h100);
        chk("oor_fc_fault", {31'd0, fault}, 32'd0);
        tick();
        chk("oor_fault", {31'd0, fault}, 32'd1);
        chk("oor_cause", {30'd0, fault_cause}, 32'd2);
        chk("oor_vld", {31'd0, if_valid}, 32'd0);
        chk("oor_pc", pc, 32'h100);
        chk("oor_cnt", fetch_count, 32'(hs_cnt));
        chk("oor_sb_empty", 32'(sb.size()), 32'd0);
        saved_cnt = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            redirect_valid = 1'($urandom_range(0, 1)); redirect_target = 32'h10;
            if_ready = 1'($urandom_range(0, 1));
            tick();
            chk("halt2_fault", {31'd0, fault}, 32'd1);
            chk("halt2_cause", {30'd0, fault_cause}, 32'd2);
            chk("halt2_pc", pc, 32'h100);
            chk("halt2_vld", {31'd0, if_valid}, 32'd0);
            chk("halt2_cnt", fetch_count, 32'(saved_cnt));
        end

        // Reset out of HALT, between edges.
        redirect_valid = 1'b0; if_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_halt");
        tick();
        rst_n = 1'b1; if_ready = 1'b1;
        sb.delete();
        push_exp(32'h0);
        tick();
        chk("r2_boot_vld", {31'd0, if_valid}, 32'd0);
        tick();
        chk("r2_ifpc", if_pc, 32'h0);
        chk("r2_vld", {31'd0, if_valid}, 32'd1);
        if_ready = 1'b0;
        tick();
        chk("r2_stall_pc", pc, 32'h4);
        chk("r2_stall_ins", if_instruction, 32'h0010_0093);

        // Reset mid-stall takes effect before the next edge.
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_stall");
        tick();
        rst_n = 1'b1; if_ready = 1'b1;
        sb.delete();
        push_exp(32'h0);
        tick();
        chk("r3_boot_vld", {31'd0, if_valid}, 32'd0);
        tick();
        chk("r3_vld", {31'd0, if_valid}, 32'd1);
        chk("r3_ifpc", if_pc, 32'h0);
        chk("r3_pc", pc, 32'h4);

        // Misaligned redirect over a live handshake: halt, pc unchanged.
        redirect_valid = 1'b1; redirect_target = 32'h42;
        tick();
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_cause", {30'd0, fault_cause}, 32'd1);
        chk("mis_vld", {31'd0, if_valid}, 32'd0);
        chk("mis_pc", pc, 32'h4);
        chk("mis_cnt", fetch_count, 32'd0);
        for (int i = 0; i < 4; i++) begin
            redirect_valid = 1'($urandom_range(0, 1)); redirect_target = 32'h80;
            if_ready = ~if_ready;
            tick();
            chk("halt1_fault", {31'd0, fault}, 32'd1);
            chk("halt1_cause", {30'd0, fault_cause}, 32'd1);
            chk("halt1_pc", pc, 32'h4);
            chk("halt1_vld", {31'd0, if_valid}, 32'd0);
            chk("halt1_cnt", fetch_count, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
